// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep harness.
//   tt_state_t : sweep FSM states
//   TT_ROWS    : rows in a 3-input truth table
//   TT_ROW_W   : row index width
//   TT_CNT_W   : settle counter width (SETTLE up to 255)
//   tt_bit()   : truth-table bit position for a row (row 000 is the MSB)
package tt_pkg;

   localparam int unsigned TT_ROWS  = 8;
   localparam int unsigned TT_ROW_W = 3;
   localparam int unsigned TT_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } tt_state_t;

   // Wolfram ordering: row 0 lands in bit 7, row 7 in bit 0.
   function automatic logic [TT_ROW_W-1:0] tt_bit(input logic [TT_ROW_W-1:0] row);
      return TT_ROW_W'(TT_ROWS - 1) - row;
   endfunction

endpackage

// File: rtl/tt_settle_cnt.sv
// Settle-interval counter: loadable-to-zero up-counter with a terminal
// count flag at SETTLE-1.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : force count to zero (has priority over i_en)
//   i_en       : advance count
//   o_tc_c     : combinational, count == SETTLE-1
module tt_settle_cnt
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc_c
);

   logic [TT_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + TT_CNT_W'(1);
      end
   end

   assign o_tc_c = (r_cnt == TT_CNT_W'(SETTLE - 1));

endmodule

// File: rtl/tt_sweep_capture.sv
// Sequential truth-table sweep harness for 3-input Wolfram-coded blocks.
// Drives rows 000..111 to the block under test, waits SETTLE cycles per
// row, samples its output into an 8-bit table and compares with EXPECTED.
// Optional feature macro: TT_STABLE_CHECK_EN (two-cycle sample with a
// sticky stability flag); undefined leaves `unstable` tied low.
//   clk, reset      : clock, synchronous active-high reset
//   start           : one-cycle sweep request, accepted only in IDLE
//   dut_out         : output of the block under test (clk-synchronous)
//   in1, in2, in3   : row drive to the block under test (in1 = MSB)
//   busy            : high while rows are being driven/sampled
//   done            : one-cycle completion pulse
//   table_q         : captured table, bit 7 = row 000
//   match           : table_q == EXPECTED, updated with done
//   unstable        : a row's two samples differed (stability build only)
module tt_sweep_capture
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE   = 2,
   parameter logic [7:0]  EXPECTED = 8'h53
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                dut_out,
   output logic                in1,
   output logic                in2,
   output logic                in3,
   output logic                busy,
   output logic                done,
   output logic [TT_ROWS-1:0]  table_q,
   output logic                match,
   output logic                unstable
);

   tt_state_t             r_state, w_state_n;
   logic [TT_ROW_W-1:0]   r_row, w_row_n;
   logic [TT_ROW_W-1:0]   r_in;
   logic                  r_busy, r_done, r_match, w_match_n;
   logic [TT_ROWS-1:0]    r_table, w_table_n;
   logic                  w_cnt_clr, w_cnt_en, w_cnt_tc, w_adv, w_drive_n;
`ifdef TT_STABLE_CHECK_EN
   logic                  r_ph, w_ph_n, r_first, w_first_n, r_unstable, w_unst_n;
`endif

   tt_settle_cnt #(.SETTLE(SETTLE)) u_settle (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_cnt_clr),
      .i_en   (w_cnt_en),
      .o_tc_c (w_cnt_tc)
   );

   // Next-state, next-row and capture logic.
   always_comb begin
      w_state_n = r_state;
      w_row_n   = r_row;
      w_table_n = r_table;
      w_match_n = r_match;
      w_cnt_clr = 1'b0;
      w_cnt_en  = 1'b0;
      w_adv     = 1'b0;
`ifdef TT_STABLE_CHECK_EN
      w_ph_n    = r_ph;
      w_first_n = r_first;
      w_unst_n  = r_unstable;
`endif
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_n = DRIVE;
               w_row_n   = '0;
               w_table_n = '0;
               w_match_n = 1'b0;
               w_cnt_clr = 1'b1;
`ifdef TT_STABLE_CHECK_EN
               w_ph_n    = 1'b0;
               w_unst_n  = 1'b0;
`endif
            end
         end
         DRIVE: begin
            if (w_cnt_tc) w_state_n = SAMPLE;
            else          w_cnt_en  = 1'b1;
         end
         SAMPLE: begin
`ifdef TT_STABLE_CHECK_EN
            // First sample goes to the table; second only checks stability.
            if (!r_ph) begin
               w_table_n[tt_bit(r_row)] = dut_out;
               w_first_n = dut_out;
               w_ph_n    = 1'b1;
            end else begin
               w_ph_n = 1'b0;
               if (dut_out != r_first) w_unst_n = 1'b1;
               w_adv = 1'b1;
            end
`else
            w_table_n[tt_bit(r_row)] = dut_out;
            w_adv = 1'b1;
`endif
         end
         DONE: w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase

      if (w_adv) begin
         if (r_row == TT_ROW_W'(TT_ROWS - 1)) begin
            w_state_n = DONE;
            w_match_n = (w_table_n == EXPECTED);
         end else begin
            w_state_n = DRIVE;
            w_row_n   = r_row + TT_ROW_W'(1);
            w_cnt_clr = 1'b1;
         end
      end

      w_drive_n = (w_state_n == DRIVE) || (w_state_n == SAMPLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_in    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_table <= '0;
         r_match <= 1'b0;
`ifdef TT_STABLE_CHECK_EN
         r_ph       <= 1'b0;
         r_first    <= 1'b0;
         r_unstable <= 1'b0;
`endif
      end else begin
         r_state <= w_state_n;
         r_row   <= w_row_n;
         r_in    <= w_drive_n ? w_row_n : '0;
         r_busy  <= w_drive_n;
         r_done  <= (w_state_n == DONE);
         r_table <= w_table_n;
         r_match <= w_match_n;
`ifdef TT_STABLE_CHECK_EN
         r_ph       <= w_ph_n;
         r_first    <= w_first_n;
         r_unstable <= w_unst_n;
`endif
      end
   end

   assign in1     = r_in[2];
   assign in2     = r_in[1];
   assign in3     = r_in[0];
   assign busy    = r_busy;
   assign done    = r_done;
   assign table_q = r_table;
   assign match   = r_match;
`ifdef TT_STABLE_CHECK_EN
   assign unstable = r_unstable;
`else
   assign unstable = 1'b0;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench for tt_sweep_capture: one instance at SETTLE=2 and one
// at SETTLE=1, each fed by a behavioural 0x53 block model.
module tb_tt_sweep_capture;

`ifdef TT_STABLE_CHECK_EN
   localparam int SAMP = 2;
`else
   localparam int SAMP = 1;
`endif
   localparam int LIMIT = 200;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;
   logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
   logic glitch_a = 1'b0, glitch_b = 1'b0;

   logic a_dut_out, a_in1, a_in2, a_in3, a_busy, a_done, a_match, a_unst;
   logic b_dut_out, b_in1, b_in2, b_in3, b_busy, b_done, b_match, b_unst;
   logic [7:0] a_tab, b_tab;

   logic [2:0] o_in;
   logic       o_busy, o_done, o_match, o_unst;
   logic [7:0] o_tab;

   int n_checks = 0;
   int n_fail   = 0;
   int q_tab[$];
   int q_match[$];
   int q_lat[$];

   always #5 clk = ~clk;

   // Behavioural block: mode 0 = 0x53 function, mode 1 = stuck at 0.
   function automatic logic model(input logic [1:0] mode, input logic [2:0] row);
      logic [7:0] code;
      code = 8'h53;
      if (mode == 2'd1) return 1'b0;
      return code[3'd7 - row];
   endfunction

   assign a_dut_out = model(mode_a, {a_in1, a_in2, a_in3}) ^ glitch_a;
   assign b_dut_out = model(mode_b, {b_in1, b_in2, b_in3}) ^ glitch_b;

   tt_sweep_capture #(.SETTLE(2), .EXPECTED(8'h53)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .dut_out(a_dut_out),
      .in1(a_in1), .in2(a_in2), .in3(a_in3), .busy(a_busy), .done(a_done),
      .table_q(a_tab), .match(a_match), .unstable(a_unst)
   );

   tt_sweep_capture #(.SETTLE(1), .EXPECTED(8'h53)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .dut_out(b_dut_out),
      .in1(b_in1), .in2(b_in2), .in3(b_in3), .busy(b_busy), .done(b_done),
      .table_q(b_tab), .match(b_match), .unstable(b_unst)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic sample_obs(input int id);
      if (id == 0) begin
         o_in = {a_in1, a_in2, a_in3}; o_busy = a_busy; o_done = a_done;
         o_tab = a_tab; o_match = a_match; o_unst = a_unst;
      end else begin
         o_in = {b_in1, b_in2, b_in3}; o_busy = b_busy; o_done = b_done;
         o_tab = b_tab; o_match = b_match; o_unst = b_unst;
      end
   endtask

   task automatic set_drive(input int id, input logic st, input logic gl);
      if (id == 0) begin start_a = st; glitch_a = gl; end
      else         begin start_b = st; glitch_b = gl; end
   endtask

   // One sweep: push expectations, pulse start, follow rows, compare at done.
   task automatic do_sweep(input int id, input int settle, input logic [1:0] mode,
                           input logic [7:0] exp_tab, input bit chk_rows,
                           input int repulse_at, input bit exp_unst);
      int per, k, lat;
      per = settle + SAMP;
      k   = 0;
      lat = -1;
      if (id == 0) mode_a = mode; else mode_b = mode;
      q_tab.push_back(int'(exp_tab));
      q_match.push_back((exp_tab == 8'h53) ? 1 : 0);
      q_lat.push_back(8 * per);
      @(negedge clk); set_drive(id, 1'b1, 1'b0);
      @(negedge clk); set_drive(id, 1'b0, 1'b0);
      while (k <= LIMIT) begin
         // Flip dut_out only during the second sample cycle of row 011.
         set_drive(id, (k == repulse_at), (mode == 2'd2) && (k == 3 * per + settle + 1));
         sample_obs(id);
         if (o_done) begin
            lat = k;
            break;
         end
         if (chk_rows) begin
            check("row", 32'(o_in), 32'(k / per));
            check("busy_on", 32'(o_busy), 32'd1);
         end
         @(negedge clk);
         k++;
      end
      set_drive(id, 1'b0, 1'b0);
      check("done_lat", 32'(lat), 32'(q_lat.pop_front()));
      check("table", 32'(o_tab), 32'(q_tab.pop_front()));
      check("match", 32'(o_match), 32'(q_match.pop_front()));
      check("rows_idle_done", 32'(o_in), 32'd0);
      check("busy_done", 32'(o_busy), 32'd0);
      check("unstable", 32'(o_unst), 32'(exp_unst));
      @(negedge clk);
      sample_obs(id);
      check("done_single", 32'(o_done), 32'd0);
      check("busy_idle", 32'(o_busy), 32'd0);
      check("table_hold", 32'(o_tab), 32'(exp_tab));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      sample_obs(0);
      check("rst_in", 32'(o_in), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_table", 32'(o_tab), 32'd0);
      check("rst_match", 32'(o_match), 32'd0);
      check("rst_unst", 32'(o_unst), 32'd0);
      reset = 1'b0;

      do_sweep(0, 2, 2'd0, 8'h53, 1'b1, -1, 1'b0);
      do_sweep(0, 2, 2'd1, 8'h00, 1'b0, -1, 1'b0);
      do_sweep(0, 2, 2'd0, 8'h53, 1'b0, 5, 1'b0);

      // Reset in the middle of a sweep discards the partial table.
      mode_a = 2'd0;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      repeat (10) @(negedge clk);
      sample_obs(0);
      check("mid_busy", 32'(o_busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      sample_obs(0);
      check("rst_mid_busy", 32'(o_busy), 32'd0);
      check("rst_mid_in", 32'(o_in), 32'd0);
      check("rst_mid_table", 32'(o_tab), 32'd0);
      check("rst_mid_done", 32'(o_done), 32'd0);
      check("rst_mid_match", 32'(o_match), 32'd0);
      reset = 1'b0;
      do_sweep(0, 2, 2'd0, 8'h53, 1'b0, -1, 1'b0);

      do_sweep(1, 1, 2'd0, 8'h53, 1'b1, -1, 1'b0);

`ifdef TT_STABLE_CHECK_EN
      do_sweep(0, 2, 2'd2, 8'h53, 1'b1, -1, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
